// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// latencies and the controller state encoding.
package md_pkg;

  // Operation encodings carried on the op port alongside start
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  // Default busy periods in clock cycles
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_core.sv
// Purely combinational arithmetic core: 64-bit signed/unsigned product and
// truncating quotient/remainder. Division by zero yields res_wr=0 so that
// HI/LO keep their previous contents.
module md_core
  import md_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_wr
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic               neg_a;
  logic               neg_b;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [31:0]        divisor;
  logic [31:0]        quo_mag;
  logic [31:0]        rem_mag;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed division is done on magnitudes and the signs are reapplied
  // afterwards; this makes 0x80000000 / -1 wrap to 0x80000000 naturally.
  assign div_signed = (op == MD_DIV);
  assign neg_a      = div_signed & src_a[31];
  assign neg_b      = div_signed & src_b[31];
  assign mag_a      = neg_a ? (~src_a + 32'd1) : src_a;
  assign mag_b      = neg_b ? (~src_b + 32'd1) : src_b;
  // Substitute a harmless divisor for zero; the result is discarded anyway
  assign divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign quo_mag    = mag_a / divisor;
  assign rem_mag    = mag_a % divisor;

  // Select the result for the requested operation
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      default: begin
        res_lo = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
        res_hi = neg_a ? (~rem_mag + 32'd1) : rem_mag;
        res_wr = (src_b != 32'd0);
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at
// the start edge and held pending; it is committed to HI/LO on the last
// busy cycle so the pipeline sees a fixed latency per operation class.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        busy_real,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  md_state_e        state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             busy_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [31:0]      pend_hi_reg;
  logic [31:0]      pend_lo_reg;
  logic             pend_wr_reg;

  logic [31:0]      core_hi;
  logic [31:0]      core_lo;
  logic             core_wr;

  md_core u_core (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .res_hi (core_hi),
    .res_lo (core_lo),
    .res_wr (core_wr)
  );

  // Controller: accept an op or an MTHI/MTLO when idle, count down when running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pend_hi_reg <= core_hi;
            pend_lo_reg <= core_lo;
            pend_wr_reg <= core_wr;
            count_reg   <= op[1] ? DIV_LOAD : MUL_LOAD;
            busy_reg    <= 1'b1;
            state_reg   <= RUN;
          end else begin
            if (mthi) hi_reg <= wdata;
            if (mtlo) lo_reg <= wdata;
          end
        end
        RUN: begin
          count_reg <= count_reg - 1'b1;
          if (count_reg == CNT_W'(1)) begin
            if (pend_wr_reg) begin
              hi_reg <= pend_hi_reg;
              lo_reg <= pend_lo_reg;
            end
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign busy_real = busy_reg | (start & ~busy_reg);
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic
// reference model of HI/LO and the per-op busy latency.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        busy_real;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total;
  int          bad;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .busy      (busy),
    .busy_real (busy_real),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural result of an op on the model HI/LO
  task automatic model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sp, sq, sr;
    logic [63:0] up;
    case (o)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi_m = sp[63:32];
        lo_m = sp[31:0];
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        hi_m = up[63:32];
        lo_m = up[31:0];
      end
      2'd2: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        lo_m = sq[31:0];
        hi_m = sr[31:0];
      end
      default: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
    endcase
  endtask

  // Issue one op from an idle negedge, measure busy length, check HI/LO
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit inject, input bit with_mt);
    int n;
    int exp_n;
    exp_n = o[1] ? 10 : 5;
    model_op(o, a, b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (with_mt) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
    #1;
    chk({tag, ".busy_real"}, {31'd0, busy_real}, 32'd1);
    chk({tag, ".busy_pre"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (inject && n == 2) begin
        start = 1'b1; op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
        mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk({tag, ".cycles"}, 32'(n), 32'(exp_n));
    chk({tag, ".hi"}, hi, hi_m);
    chk({tag, ".lo"}, lo, lo_m);
    $display("op %s op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", tag, o, a, b, n, hi, lo);
  endtask

  // MTHI/MTLO on an idle cycle
  task automatic do_mt(input string tag, input bit h, input bit l, input logic [31:0] d);
    mthi = h; mtlo = l; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) hi_m = d;
    if (l) lo_m = d;
    chk({tag, ".hi"}, hi, hi_m);
    chk({tag, ".lo"}, lo, lo_m);
    $display("mt %s mthi=%0b mtlo=%0b d=%h hi=%h lo=%h", tag, h, l, d, hi, lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    total = 0; bad = 0;
    hi_m = 32'd0; lo_m = 32'd0;
    reset = 1'b0; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    #12;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.busy_real", {31'd0, busy_real}, 32'd0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("mult_neg3x5.hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg3x5.lo_const", lo, 32'hFFFF_FFF1);
    do_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("divu_100_7.lo_const", lo, 32'h0000_000E);
    do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_m7_2.lo_const", lo, 32'hFFFF_FFFD);
    do_mt("mthi", 1'b1, 1'b0, 32'h0000_1234);
    do_mt("mtlo", 1'b0, 1'b1, 32'h0000_5678);
    do_op("div_by_zero", 2'd2, 32'd99, 32'd0, 1'b0, 1'b0);
    chk("div_by_zero.hi_const", hi, 32'h0000_1234);
    do_op("multu_inject", 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    chk("multu_inject.hi_const", hi, 32'd1);
    do_op("start_with_mthi", 2'd0, 32'd11, 32'd13, 1'b0, 1'b1);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf.lo_const", lo, 32'h8000_0000);
    do_mt("mt_both", 1'b1, 1'b1, 32'hA5A5_0F0F);

    // Abort a DIV with reset in its third busy cycle
    start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    hi_m = 32'd0; lo_m = 32'd0;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.hi", hi, 32'd0);
    chk("abort.lo", lo, 32'd0);
    $display("abort reset during div busy=%0b hi=%h lo=%h", busy, hi, lo);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_abort.busy", {31'd0, busy}, 32'd0);
    do_op("mult_6x7", 2'd0, 32'd6, 32'd7, 1'b0, 1'b0);
    chk("mult_6x7.lo_const", lo, 32'd42);

    // Randomized ops and HI/LO writes
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      if ($urandom_range(0, 4) == 0)
        do_mt("rand_mt", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      do_op("rand_op", 2'($urandom_range(0, 3)), ra, rb,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
